// File: rtl/gate_seq_pkg.sv
// Shared types and default sizing for the gate vector sequencer.
//
// Contents:
//   seq_state_e       - sweep FSM states
//   DEFAULT_N_IN      - default number of gate inputs driven
//   DEFAULT_SETTLE_W  - default width of the settle-cycle count
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  localparam int DEFAULT_N_IN     = 2;
  localparam int DEFAULT_SETTLE_W = 4;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag, used to time the settle wait
// between driving a vector onto the gate and sampling its output.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   async active-high reset (count -> 0)
//   load      in   load load_val into the counter (wins over dec)
//   load_val  in   W-bit value to load
//   dec       in   decrement by one (ignored when already zero)
//   zero      out  high when the count is zero
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive truth-table sweeper for a small combinational gate. On start it
// captures the settle time and the expected truth table, then walks every
// input vector: drive it, wait settle_cycles, sample dut_y and record any
// mismatch in fail_mask. A one-cycle done pulse and a pass flag report the
// result.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   async active-high reset
//   start          in   begin a sweep (only honoured in IDLE)
//   abort          in   terminate a sweep, back to IDLE
//   settle_cycles  in   SETTLE_W-bit wait between drive and sample
//   expected_tt    in   NV-bit expected truth table, bit i for dut_in==i
//   dut_y          in   output of the gate under control
//   dut_in         out  N_IN-bit gate inputs (0 outside a sweep)
//   busy           out  sweep in progress
//   done           out  one-cycle pulse at sweep completion
//   pass           out  last completed sweep had no mismatches
//   fail_mask      out  NV-bit per-vector mismatch flags
//   vec_idx        out  index of the vector currently applied
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN     = DEFAULT_N_IN,
  parameter int SETTLE_W = DEFAULT_SETTLE_W,
  localparam int NV      = 2**N_IN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [NV-1:0]       expected_tt,
  input  logic                dut_y,
  output logic [N_IN-1:0]     dut_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NV-1:0]       fail_mask,
  output logic [N_IN-1:0]     vec_idx
);

  seq_state_e          state_q,     state_d;
  logic [N_IN-1:0]     vec_idx_q,   vec_idx_d;
  logic [N_IN-1:0]     dut_in_q,    dut_in_d;
  logic [NV-1:0]       fail_mask_q, fail_mask_d;
  logic                pass_q,      pass_d;
  logic [SETTLE_W-1:0] settle_q,    settle_d;
  logic [NV-1:0]       exp_tt_q,    exp_tt_d;

  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic                last_vec;
  logic                mismatch;

  // The timer is loaded with S-1 so that SETTLE lasts exactly S cycles:
  // it leaves on the cycle the count reads zero.
  settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (settle_q - SETTLE_W'(1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign last_vec = (vec_idx_q == N_IN'(NV - 1));
  assign mismatch = (dut_y != exp_tt_q[vec_idx_q]);

  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    settle_d    = settle_q;
    exp_tt_d    = exp_tt_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    // Abort overrides normal sequencing from any active state; the partial
    // fail_mask is deliberately kept for post-mortem.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            settle_d    = settle_cycles;
            exp_tt_d    = expected_tt;
            fail_mask_d = '0;
            pass_d      = 1'b0;
            vec_idx_d   = '0;
            state_d     = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (settle_q != '0) begin
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_d = ST_SAMPLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_mask_d[vec_idx_q] = 1'b1;
          end
          if (last_vec) begin
            pass_d  = ~|fail_mask_d;
            state_d = ST_DONE;
          end else begin
            vec_idx_d = vec_idx_q + N_IN'(1);
            state_d   = ST_DRIVE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // dut_in is registered from the next state so the gate sees the new
    // vector for the whole DRIVE..SAMPLE window and 0 otherwise.
    if ((state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) begin
      dut_in_d = vec_idx_d;
    end else begin
      dut_in_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_idx_q   <= '0;
      dut_in_q    <= '0;
      fail_mask_q <= '0;
      pass_q      <= 1'b0;
      settle_q    <= '0;
      exp_tt_q    <= '0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      dut_in_q    <= dut_in_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      settle_q    <= settle_d;
      exp_tt_q    <= exp_tt_d;
    end
  end

  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign vec_idx   = vec_idx_q;
  assign dut_in    = dut_in_q;

endmodule

// File: doc/gate_vector_sequencer.md
GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 Parameter N_IN, default 2: number of gate inputs driven; vector count NV = 2**N_IN.
REQ-002 Parameter SETTLE_W, default 4: width of settle-cycle count.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-high reset.
REQ-006 start  input  1  begin a sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate a sweep; return to IDLE.
REQ-008 settle_cycles  input  SETTLE_W  wait cycles between drive and sample; captured on start.
REQ-009 expected_tt  input  NV  expected gate output per vector; bit i = expected y for dut_in==i; captured on start.
REQ-010 dut_y  input  1  output of the gate under control.
REQ-011 dut_in  output  N_IN  gate inputs; for the 2-input gate, dut_in[1]=a, dut_in[0]=b.
REQ-012 busy  output  1  high from the cycle after an accepted start until DONE or abort.
REQ-013 done  output  1  one-cycle pulse at sweep completion.
REQ-014 pass  output  1  high when the last completed sweep had no mismatches; held until the next accepted start.
REQ-015 fail_mask  output  NV  bit i set when vector i mismatched; held until the next accepted start.
REQ-016 vec_idx  output  N_IN  index of the vector currently applied.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL capture settle_cycles and expected_tt, clear fail_mask, pass and vec_idx, and go to DRIVE.
REQ-019 DRIVE (1 cycle): dut_in SHALL be registered to vec_idx; next is SETTLE if captured settle_cycles>0, else SAMPLE.
REQ-020 SETTLE: the block SHALL remain in SETTLE for exactly settle_cycles cycles, then go to SAMPLE; dut_in SHALL stay stable.
REQ-021 SAMPLE (1 cycle): on a mismatch (dut_y != expected_tt[vec_idx]), fail_mask[vec_idx] SHALL be set. If vec_idx==NV-1, next is DONE; otherwise vec_idx increments and next is DRIVE.
REQ-022 DONE (1 cycle): done=1, pass SHALL equal ~|fail_mask, busy=0, dut_in=0; next is IDLE.
REQ-023 Latency: done SHALL be high in cycle 1+NV*(2+S) after the start edge, where S = captured settle_cycles. For N_IN=2, S=0, that is cycle 9.
REQ-024 start while busy SHALL be ignored; input changes after capture SHALL have no effect.
REQ-025 abort in any non-IDLE state SHALL go to IDLE next cycle: busy=0, dut_in=0, no done pulse, and pass=0; fail_mask SHALL keep its partial value.
REQ-026 start and abort both high in IDLE: abort wins, and the FSM SHALL stay in IDLE.
REQ-027 In IDLE, dut_in SHALL be 0.
REQ-028 vec_idx SHALL not wrap past NV-1 within a sweep.

Reset
REQ-029 rst=1 SHALL force IDLE immediately: dut_in=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0, and the captured registers SHALL be 0.
REQ-030 Reset mid-sweep SHALL discard the sweep; no done pulse SHALL follow deassertion.

Structure
REQ-031 Package gate_seq_pkg SHALL hold the state enum type and the default N_IN/SETTLE_W constants.
REQ-032 One sub-module, settle_timer (loadable down-counter with zero flag), SHALL implement the SETTLE wait.

Verification
REQ-033 2-input AND gate, expected_tt=4'b1000, S=0, start -> done in cycle 9, pass=1, fail_mask=4'b0000; dut_in sequence 00,01,10,11.
REQ-034 AND gate, expected_tt=4'b1110 (OR table), S=0 -> pass=0, fail_mask=4'b0110.
REQ-035 AND gate, S=3 -> done in cycle 21; each dut_in value held for 5 cycles; pass=1.
REQ-036 abort asserted during SETTLE of vec_idx=2 -> busy=0 and dut_in=0 next cycle, no done, pass=0, fail_mask unchanged.
REQ-037 Second start mid-sweep; and start+abort together in IDLE -> first case: sweep timing unchanged; second case: busy stays 0.
REQ-038 rst pulse during SAMPLE of vec_idx=1 -> all outputs 0 the same cycle, FSM in IDLE, no done after release.
